// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry instruction prefetch queue between the shared bus and
// the control/decode unit. The head entry is presented as ir_out, split into
// opcode and operand fields.
// Optional macro IR_QUEUE_OVF_EN adds a sticky overflow flag output (ir_ovf).
module ir_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OPC_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ir_write,
  input  logic [WIDTH-1:0]         bus,
  input  logic                     ir_next,
  input  logic                     flush,
  output logic                     ir_valid,
  output logic                     ir_full,
  output logic [WIDTH-1:0]         ir_out,
  output logic [OPC_W-1:0]         opcode,
  output logic [WIDTH-OPC_W-1:0]   operand,
  output logic [$clog2(DEPTH):0]   level
`ifdef IR_QUEUE_OVF_EN
  ,
  output logic                     ir_ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Status flags come only from the registered count.
  always_comb begin
    ir_valid = (count != '0);
    ir_full  = (count == CW'(DEPTH));
    level    = count;
  end

  // Accept conditions; flush suppresses both, and a full queue can still take
  // a push when the head is retired in the same cycle.
  always_comb begin
    pop  = ir_next && !flush && ir_valid;
    push = ir_write && !flush && (!ir_full || pop);
  end

  // Head word is forced to zero while empty; opcode/operand are pure slices.
  always_comb begin
    ir_out  = ir_valid ? mem[rd_ptr] : '0;
    opcode  = ir_out[WIDTH-1 -: OPC_W];
    operand = ir_out[WIDTH-OPC_W-1:0];
  end

  // Storage array, written at the tail on an accepted push; not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus;
    end
  end

  // Pointer and occupancy tracking; flush returns everything to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef IR_QUEUE_OVF_EN
  // Sticky flag for a push rejected because the queue was full with no pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_ovf <= 1'b0;
    end else if (flush) begin
      ir_ovf <= 1'b0;
    end else if (ir_write && ir_full && !pop) begin
      ir_ovf <= 1'b1;
    end
  end
`endif

endmodule
